// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared mode encoding and saturate-and-flag helper for the MAC pipe
package dsp_pkg;

   typedef enum logic [1:0] {
      MODE_MAC  = 2'b00,
      MODE_ACC  = 2'b01,
      MODE_LOAD = 2'b10
   } mode_t;

   localparam int SAT_MAXW = 64;

   typedef struct packed {
      logic                       ovf;
      logic signed [SAT_MAXW-1:0] val;
   } sat_t;

   // Clamp v into the signed dw-bit range; ovf reports that the value changed.
   function automatic sat_t saturate(input logic signed [SAT_MAXW-1:0] v, input int dw);
      logic signed [SAT_MAXW-1:0] hi;
      logic signed [SAT_MAXW-1:0] lo;
      sat_t res;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      res.ovf = 1'b0;
      res.val = v;
      if (v > hi) begin
         res.ovf = 1'b1;
         res.val = hi;
      end else if (v < lo) begin
         res.ovf = 1'b1;
         res.val = lo;
      end
      return res;
   endfunction

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// rtl/dsp_mac_pipe_if.sv - input beat and output beat handshake bundle for dsp_mac_pipe
interface dsp_mac_pipe_if #(parameter int DW = 8);

   logic                 s_valid;
   logic                 s_ready;
   logic signed [DW-1:0] a;
   logic signed [DW-1:0] b;
   logic signed [DW-1:0] c;
   logic signed [DW-1:0] d;
   logic [1:0]           mode;
   logic                 m_valid;
   logic                 m_ready;
   logic signed [DW-1:0] m_tdata;
   logic                 overflow;

   modport master (
      output s_valid, a, b, c, d, mode, m_ready,
      input  s_ready, m_valid, m_tdata, overflow
   );

   modport slave (
      input  s_valid, a, b, c, d, mode, m_ready,
      output s_ready, m_valid, m_tdata, overflow
   );

endinterface

// File: rtl/dsp_sat.sv
// rtl/dsp_sat.sv - result shift, optional round-half-up (DSP_MAC_ROUND_EN) and clamp to DW bits
module dsp_sat
   import dsp_pkg::*;
#(
   parameter int ACCW  = 20,
   parameter int DW    = 8,
   parameter int SHIFT = 1
) (
   input  logic signed [ACCW-1:0] r,
   output logic signed [DW-1:0]   q,
   output logic                   ovf
);

   logic signed [ACCW-1:0]     rr;
   logic signed [ACCW-1:0]     shifted;
   logic signed [SAT_MAXW-1:0] ext;
   sat_t                       s;

`ifdef DSP_MAC_ROUND_EN
   // Half an output LSB is added before the shift; the sum wraps in ACCW bits.
   if (SHIFT > 0) begin : g_round
      localparam logic signed [ACCW-1:0] RND = ACCW'(1) << (SHIFT - 1);
      assign rr = r + RND;
   end else begin : g_no_round
      assign rr = r;
   end
`else
   assign rr = r;
`endif

   assign shifted = rr >>> SHIFT;
   assign ext     = SAT_MAXW'(shifted);
   assign s       = saturate(ext, DW);
   assign q       = DW'(s.val);
   assign ovf     = s.ovf;

endmodule

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - 3-stage pre-add/multiply/post-add MAC with accumulator and saturated output
// Rounding before the output shift is enabled by defining DSP_MAC_ROUND_EN.
module dsp_mac_pipe
   import dsp_pkg::*;
#(
   parameter int DW    = 8,
   parameter int ACCW  = 2*DW + 4,
   parameter int SHIFT = 1
) (
   input  logic         clk,
   input  logic         rst,
   dsp_mac_pipe_if.slave io
);

   logic                   en;
   logic                   v1, v2;
   logic signed [DW:0]     p1_q;
   logic signed [DW-1:0]   b1_q;
   logic signed [ACCW-1:0] c1_q, c2_q, p2_q, acc_q, r;
   logic [1:0]             mode1_q, mode2_q;
   logic signed [2*DW:0]   prod;
   logic signed [DW-1:0]   sat_data;
   logic                   sat_ovf;

   // One enable stalls every stage, so a held output freezes the whole pipe.
   assign en         = !io.m_valid || io.m_ready;
   assign io.s_ready = en;

   assign prod = (2*DW+1)'(p1_q) * (2*DW+1)'(b1_q);

   // acc is written by the beat leaving S3, so the next ACC beat already sees it.
   always_comb begin
      r = p2_q + c2_q;
      if (mode2_q == MODE_ACC) begin
         r = acc_q + p2_q + c2_q;
      end
   end

   dsp_sat #(
      .ACCW  (ACCW),
      .DW    (DW),
      .SHIFT (SHIFT)
   ) u_sat (
      .r   (r),
      .q   (sat_data),
      .ovf (sat_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         p1_q        <= '0;
         b1_q        <= '0;
         c1_q        <= '0;
         mode1_q     <= '0;
         p2_q        <= '0;
         c2_q        <= '0;
         mode2_q     <= '0;
         acc_q       <= '0;
         io.m_valid  <= 1'b0;
         io.m_tdata  <= '0;
         io.overflow <= 1'b0;
      end else if (en) begin
         v1          <= io.s_valid;
         p1_q        <= (DW+1)'(io.a) - (DW+1)'(io.d);
         b1_q        <= io.b;
         c1_q        <= ACCW'(io.c);
         mode1_q     <= io.mode;
         v2          <= v1;
         p2_q        <= ACCW'(prod);
         c2_q        <= c1_q;
         mode2_q     <= mode1_q;
         io.m_valid  <= v2;
         io.m_tdata  <= sat_data;
         io.overflow <= sat_ovf;
         if (v2 && (mode2_q == MODE_ACC || mode2_q == MODE_LOAD)) begin
            acc_q <= r;
         end
      end
   end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - directed self-checking bench for dsp_mac_pipe (SHIFT=0 and SHIFT=1 instances)
module tb_dsp_mac_pipe;
   import dsp_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   q_data[$];
   logic q_ovf[$];

   always #5 clk = ~clk;

   dsp_mac_pipe_if #(.DW(8)) ifc0 ();
   dsp_mac_pipe_if #(.DW(8)) ifc1 ();

   dsp_mac_pipe #(.DW(8), .ACCW(20), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .io(ifc0));
   dsp_mac_pipe #(.DW(8), .ACCW(20), .SHIFT(1)) dut1 (.clk(clk), .rst(rst), .io(ifc1));

   // Outputs that will transfer on the coming edge are recorded mid-cycle.
   always @(negedge clk) begin
      if (!rst && ifc0.m_valid && ifc0.m_ready) begin
         q_data.push_back(int'(ifc0.m_tdata));
         q_ovf.push_back(ifc0.overflow);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send0(input int a, input int d, input int b, input int c, input logic [1:0] m);
      int cnt = 0;
      ifc0.a = 8'(a); ifc0.d = 8'(d); ifc0.b = 8'(b); ifc0.c = 8'(c); ifc0.mode = m;
      ifc0.s_valid = 1'b1;
      #0;
      while (!ifc0.s_ready && cnt < 50) begin
         step();
         cnt++;
      end
      chk("send0_accept", 32'(cnt < 50), 1);
      step();
      ifc0.s_valid = 1'b0;
   endtask

   task automatic expect0(input string tag, input int exp_d, input logic exp_o);
      int cnt = 0;
      while (q_data.size() == 0 && cnt < 30) begin
         step();
         cnt++;
      end
      chk({tag, "_present"}, 32'(q_data.size() != 0), 1);
      if (q_data.size() != 0) begin
         chk({tag, "_data"}, q_data.pop_front(), exp_d);
         chk({tag, "_ovf"}, 32'(q_ovf.pop_front()), 32'(exp_o));
      end
   endtask

   task automatic send1(input int a, input int d, input int b, input int c);
      ifc1.a = 8'(a); ifc1.d = 8'(d); ifc1.b = 8'(b); ifc1.c = 8'(c); ifc1.mode = MODE_MAC;
      ifc1.s_valid = 1'b1;
      step();
      ifc1.s_valid = 1'b0;
   endtask

   task automatic out1(input string tag, input int exp_d, input logic exp_o);
      int cnt = 0;
      while (!ifc1.m_valid && cnt < 20) begin
         step();
         cnt++;
      end
      chk({tag, "_valid"}, 32'(ifc1.m_valid), 1);
      chk({tag, "_data"}, ifc1.m_tdata, exp_d);
      chk({tag, "_ovf"}, 32'(ifc1.overflow), 32'(exp_o));
      step();
   endtask

   initial begin
      int  idx;
      logic sr;
      ifc0.s_valid = 1'b0; ifc0.a = '0; ifc0.b = '0; ifc0.c = '0; ifc0.d = '0;
      ifc0.mode = MODE_MAC; ifc0.m_ready = 1'b1;
      ifc1.s_valid = 1'b0; ifc1.a = '0; ifc1.b = '0; ifc1.c = '0; ifc1.d = '0;
      ifc1.mode = MODE_MAC; ifc1.m_ready = 1'b1;

      // Reset state
      rst = 1'b1;
      step();
      step();
      chk("rst_m_valid", 32'(ifc0.m_valid), 0);
      chk("rst_m_tdata", ifc0.m_tdata, 0);
      chk("rst_overflow", 32'(ifc0.overflow), 0);
      rst = 1'b0;
      step();
      chk("rst_s_ready", 32'(ifc0.s_ready), 1);

      // Latency: accept at edge 1, m_valid after edge 3
      ifc0.a = 8'(10); ifc0.d = 8'(3); ifc0.b = 8'(4); ifc0.c = 8'(5); ifc0.mode = MODE_MAC;
      ifc0.s_valid = 1'b1;
      #0;
      chk("lat_s_ready", 32'(ifc0.s_ready), 1);
      step();
      ifc0.s_valid = 1'b0;
      chk("lat_c1_m_valid", 32'(ifc0.m_valid), 0);
      step();
      chk("lat_c2_m_valid", 32'(ifc0.m_valid), 0);
      step();
      chk("lat_c3_m_valid", 32'(ifc0.m_valid), 1);
      expect0("mac33", 33, 1'b0);

      // Saturation both ways
      send0(127, -128, 127, 0, MODE_MAC);
      send0(-128, 127, 127, 0, MODE_MAC);
      expect0("sat_pos", 127, 1'b1);
      expect0("sat_neg", -128, 1'b1);

      // LOAD then back-to-back ACC, MAC leaves acc, mode 11 behaves as MAC
      send0(1, 0, 2, 0, MODE_LOAD);
      send0(1, 0, 2, 0, MODE_ACC);
      send0(1, 0, 2, 0, MODE_ACC);
      send0(1, 0, 2, 0, MODE_ACC);
      send0(1, 0, 2, 0, MODE_MAC);
      send0(1, 0, 2, 0, MODE_ACC);
      send0(1, 0, 2, 0, 2'b11);
      send0(1, 0, 2, 0, MODE_ACC);
      expect0("load", 2, 1'b0);
      expect0("acc1", 4, 1'b0);
      expect0("acc2", 6, 1'b0);
      expect0("acc3", 8, 1'b0);
      expect0("mac_after_acc", 2, 1'b0);
      expect0("acc_kept", 10, 1'b0);
      expect0("mode11", 2, 1'b0);
      expect0("acc_after_m11", 12, 1'b0);
      repeat (4) step();

      // Backpressure: six beats offered, m_ready low for five cycles
      idx = 0;
      for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
         ifc0.s_valid = 1'b1;
         ifc0.a = 8'(idx + 1); ifc0.d = '0; ifc0.b = 8'(1); ifc0.c = '0; ifc0.mode = MODE_MAC;
         ifc0.m_ready = (cyc >= 5);
         #1;
         if (cyc == 3 || cyc == 4) begin
            chk($sformatf("bp_c%0d_s_ready", cyc), 32'(ifc0.s_ready), 0);
            chk($sformatf("bp_c%0d_m_valid", cyc), 32'(ifc0.m_valid), 1);
            chk($sformatf("bp_c%0d_m_tdata", cyc), ifc0.m_tdata, 1);
         end
         sr = ifc0.s_ready;
         step();
         if (sr) idx++;
      end
      ifc0.s_valid = 1'b0;
      ifc0.m_ready = 1'b1;
      chk("bp_all_accepted", idx, 6);
      for (int i = 1; i <= 6; i++) begin
         expect0($sformatf("bp_out%0d", i), i, 1'b0);
      end
      repeat (6) step();
      chk("bp_no_dup", q_data.size(), 0);

      // Mid-stream reset with three ACC beats in flight
      send0(1, 0, 2, 6, MODE_LOAD);
      expect0("pre_rst_load", 8, 1'b0);
      ifc0.m_ready = 1'b0;
      send0(1, 0, 2, 0, MODE_ACC);
      send0(1, 0, 2, 0, MODE_ACC);
      send0(1, 0, 2, 0, MODE_ACC);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_m_valid", 32'(ifc0.m_valid), 0);
      chk("midrst_m_tdata", ifc0.m_tdata, 0);
      chk("midrst_overflow", 32'(ifc0.overflow), 0);
      ifc0.m_ready = 1'b1;
      send0(1, 0, 2, 0, MODE_ACC);
      expect0("post_rst_acc", 2, 1'b0);
      repeat (6) step();
      chk("post_rst_no_stale", q_data.size(), 0);

      // SHIFT=1 instance
`ifdef DSP_MAC_ROUND_EN
      send1(10, 3, 4, 5);
      out1("sh1_pos", 17, 1'b0);
      send1(3, 10, 4, -5);
      out1("sh1_neg", -16, 1'b0);
`else
      send1(10, 3, 4, 5);
      out1("sh1_pos", 16, 1'b0);
      send1(3, 10, 4, -5);
      out1("sh1_neg", -17, 1'b0);
`endif
      send1(127, -128, 127, 0);
      out1("sh1_sat", 127, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 Parameter DW, default 8: signed operand and output width, DW >= 4.
REQ-002 Parameter ACCW, default 2*DW+4: signed accumulator and result width, ACCW >= 2*DW+2.
REQ-003 Parameter SHIFT, default 1: arithmetic right shift applied to the result before saturation, 0 <= SHIFT < ACCW-DW.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 s_valid  in  1  input beat valid.
REQ-007 s_ready  out  1  block can accept an input beat.
REQ-008 a, b, c, d  in  DW each  signed operands.
REQ-009 mode  in  2  per-beat op: 00 MAC, 01 ACC, 10 LOAD, 11 treated as MAC.
REQ-010 m_valid  out  1  output beat valid.
REQ-011 m_ready  in  1  downstream accepts the output beat.
REQ-012 m_tdata  out  DW  signed saturated result.
REQ-013 overflow  out  1  saturation occurred on the current output beat.

Function
REQ-014 The pipeline SHALL have 3 stages: S1 pre-add p1=a-d (DW+1 bits), S2 multiply p2=p1*b (2*DW+1 bits, sign-extended to ACCW), S3 post-add and saturate.
REQ-015 S3 SHALL compute r: MAC r=p2+c; ACC r=acc+p2+c; LOAD r=p2+c. c is sign-extended to ACCW and carried with its beat through S1-S2.
REQ-016 acc SHALL update to r only when an ACC or LOAD beat leaves S3 into the output register; MAC beats leave acc unchanged; r wraps modulo 2^ACCW.
REQ-017 The output value SHALL be r>>>SHIFT, clamped to [-2^(DW-1), 2^(DW-1)-1]; overflow=1 exactly when clamping changed the value.
REQ-018 A beat transfers on s_valid&&s_ready; the output transfers on m_valid&&m_ready.
REQ-019 Global enable en = !m_valid || m_ready; s_ready = en; all stage registers and valid bits advance only when en=1.
REQ-020 Latency SHALL be 3 cycles from input accept to m_valid=1 with m_ready held high; throughput 1 beat/cycle.
REQ-021 While m_valid=1 and m_ready=0, m_tdata, overflow and m_valid SHALL hold stable and no beat may be lost, duplicated or reordered.
REQ-022 Back-to-back ACC beats SHALL each see acc including all earlier beats (no read-after-write bubble).
REQ-023 Bubbles (stage valid=0) SHALL NOT modify acc.

Reset
REQ-024 During rst: all stage valid bits, m_valid, overflow, m_tdata and acc SHALL be 0 on the next edge; s_ready=1 in the cycle after reset deasserts.
REQ-025 rst asserted mid-stream SHALL discard all in-flight beats; no output beat from before reset appears afterwards.

Configuration
REQ-026 Macro DSP_MAC_ROUND_EN defined: when SHIFT>0, 2^(SHIFT-1) SHALL be added to r before the shift (round half up), within ACCW wrap rules.
REQ-027 Macro undefined: plain truncating arithmetic shift; no rounding logic is synthesised.

Structure
REQ-028 A shared package dsp_pkg SHALL hold the mode enum (MODE_MAC, MODE_ACC, MODE_LOAD) and the saturate-and-flag function.
REQ-029 One sub-module, dsp_sat, SHALL implement shift/round/clamp, parametrised by ACCW, DW and SHIFT.

Verification (DW=8, ACCW=20)
REQ-030 SHIFT=0, MAC, a=10 d=3 b=4 c=5 -> m_tdata=33, overflow=0, m_valid 3 cycles after accept.
REQ-031 SHIFT=0, MAC, a=127 d=-128 b=127 c=0 -> 127, overflow=1; a=-128 d=127 b=127 c=0 -> -128, overflow=1.
REQ-032 SHIFT=0, LOAD a=1 d=0 b=2 c=0, then three ACC beats a=1 d=0 b=2 c=0 back-to-back -> outputs 2,4,6,8; then MAC same operands -> 2, and acc stays 8.
REQ-033 Offer 6 consecutive beats with m_ready=0 for 5 cycles, then 1 -> s_ready falls once the pipe is full; all 6 results emerge in order, none lost or duplicated.
REQ-034 SHIFT=1, MAC a=10 d=3 b=4 c=5 (r=33) -> 16 without DSP_MAC_ROUND_EN, 17 with it.
REQ-035 Assert rst for 1 cycle with 3 beats in flight and acc=8 -> m_valid=0, acc=0; the next ACC a=1 d=0 b=2 c=0 -> 2.
